// File: rtl/clcd_req_arbiter.sv
// clcd_req_arbiter: shares the CLCD_signal_generator command port between
// NREQ requesters. One command is latched per grant, issued as a single-cycle
// valid, and tracked through the generator's busy high/low handshake before a
// per-requester done pulse is returned.
module clcd_req_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PRIO0 = 1,
    parameter int unsigned TMO   = 255
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_data,
    input  logic [NREQ-1:0]   i_RS,
    input  logic [NREQ-1:0]   i_RW,
    output logic [NREQ-1:0]   o_gnt,
    output logic [NREQ-1:0]   o_done,
    output logic [7:0]        o_data,
    output logic              o_RS,
    output logic              o_RW,
    output logic              o_valid,
    input  logic              i_busy,
    output logic              o_timeout,
    output logic              o_idle
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LATCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]      state;
    logic [2:0]      nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [CW-1:0]   cnt;

    logic [IW-1:0]   sel_c;
    logic [IW-1:0]   idx_c;
    logic            sel_found_c;
    logic [7:0]      sel_data_c;
    logic            sel_rs_c;
    logic            sel_rw_c;
    logic            tmo_hit_c;
    logic            accept_c;

    // Winner selection: optional absolute priority for the init path, else round-robin after ptr
    always_comb begin
        sel_c       = ptr;
        sel_found_c = 1'b0;
        idx_c       = '0;
        if ((PRIO0 != 0) && i_req[0]) begin
            sel_c       = '0;
            sel_found_c = 1'b1;
        end
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_c = IW'((32'(ptr) + k) % NREQ);
            if (!sel_found_c && i_req[idx_c]) begin
                sel_c       = idx_c;
                sel_found_c = 1'b1;
            end
        end
    end

    // Command field mux for the selected requester
    always_comb begin
        sel_data_c = 8'h00;
        sel_rs_c   = 1'b0;
        sel_rw_c   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (sel_c == IW'(k)) begin
                sel_data_c = i_data[8*k +: 8];
                sel_rs_c   = i_RS[k];
                sel_rw_c   = i_RW[k];
            end
        end
    end

    // Next-state logic; busy rising wins over a same-cycle timeout
    always_comb begin
        nxt       = state;
        tmo_hit_c = 1'b0;
        accept_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!i_busy && (|i_req)) begin
                    nxt      = S_LATCH;
                    accept_c = 1'b1;
                end
            end
            S_LATCH:  nxt = S_ISSUE;
            S_ISSUE:  nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (i_busy) begin
                    nxt = S_WAIT_LO;
                end else if (cnt == CW'(TMO - 2)) begin
                    nxt       = S_DONE;
                    tmo_hit_c = 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!i_busy) begin
                    nxt = S_DONE;
                end
            end
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // State register and busy-rise timeout counter (cnt counts WAIT_HI cycles)
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT_HI) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Grant, command latch and pointer; captured on entry to LATCH so they are valid throughout it
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ptr    <= '0;
            win    <= '0;
            o_gnt  <= '0;
            o_data <= 8'h00;
            o_RS   <= 1'b0;
            o_RW   <= 1'b0;
        end else begin
            if (accept_c) begin
                ptr    <= sel_c;
                win    <= sel_c;
                o_gnt  <= NREQ'(1) << sel_c;
                o_data <= sel_data_c;
                o_RS   <= sel_rs_c;
                o_RW   <= sel_rw_c;
            end else if (state == S_DONE) begin
                o_gnt <= '0;
            end
        end
    end

    // Handshake pulses and status flags
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            o_valid   <= 1'b0;
            o_done    <= '0;
            o_timeout <= 1'b0;
            o_idle    <= 1'b1;
        end else begin
            o_valid   <= (nxt == S_ISSUE);
            o_done    <= (nxt == S_DONE) ? (NREQ'(1) << win) : '0;
            o_timeout <= o_timeout | tmo_hit_c;
            o_idle    <= (nxt == S_IDLE) && !(|i_req) && !i_busy;
        end
    end

endmodule

// File: doc/clcd_req_arbiter.md
Name: clcd_req_arbiter

Overview:
- Shares the single CLCD_signal_generator command port between NREQ requesters: the CLCD init register bank, system_control and the keypad echo path.
- Replaces the combinational empty-based mux in front of the generator.
- Latches one command per grant, issues a single-cycle valid, and tracks the generator's busy to command completion.
- Returns a per-requester done pulse.

Parameters:
- NREQ, 3: number of requesters; index 0 is the init path.
- PRIO0, 1: 1 = requester 0 has absolute priority over round-robin; 0 = pure round-robin.
- TMO, 255: clk cycles to wait for i_busy to rise after o_valid before declaring a timeout.

Ports:
- clk  in  1  system clock
- reset_p  in  1  asynchronous active-high reset
- i_req  in  NREQ  per-requester request level; held until the matching o_done
- i_data  in  8*NREQ  packed command bytes; requester k uses bits [8k+7:8k]
- i_RS  in  NREQ  per-requester RS
- i_RW  in  NREQ  per-requester RW
- o_gnt  out  NREQ  one-hot grant, high from the LATCH state through DONE
- o_done  out  NREQ  one-cycle completion pulse to the granted requester
- o_data  out  8  command byte to CLCD_signal_generator i_data
- o_RS  out  1  to generator i_RS
- o_RW  out  1  to generator i_RW
- o_valid  out  1  to generator i_valid; single-cycle pulse
- i_busy  in  1  from generator o_busy
- o_timeout  out  1  sticky error flag; cleared only by reset
- o_idle  out  1  high in IDLE with no request pending

Behaviour:
- Reset (async, reset_p=1) forces:
  - o_gnt=0, o_done=0, o_data=8'h00, o_RS=0, o_RW=0, o_valid=0, o_timeout=0, o_idle=1
  - round-robin pointer=0, state=IDLE, timeout counter=0
- Reset mid-transaction drops everything immediately; no o_done is emitted for the aborted command.
- FSM states: IDLE, LATCH, ISSUE, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - If i_busy=1, stay (the generator is still finishing a previous or foreign command).
  - Else, if any i_req bit is set, select the winner and go to LATCH.
- Selection:
  - If PRIO0=1 and i_req[0]=1, requester 0 wins.
  - Otherwise, search from pointer+1 modulo NREQ upward; the first set bit wins.
  - The pointer is updated to the winner index in LATCH, including when requester 0 wins by priority.
- LATCH (1 cycle):
  - Register the winner's data, RS and RW into o_data, o_RS, o_RW.
  - Set o_gnt one-hot.
  - These outputs stay stable until DONE completes.
- ISSUE (1 cycle): o_valid=1; clear the timeout counter.
- WAIT_HI:
  - Wait for i_busy=1, then go to WAIT_LO.
  - The counter increments each cycle. On reaching TMO with i_busy still 0, set o_timeout=1 and go to DONE; the command is treated as lost and is not retried.
- WAIT_LO: wait for i_busy=0, with no timeout (I2C transfers run on the slow clock). Then go to DONE.
- DONE (1 cycle):
  - o_done[winner]=1.
  - o_gnt clears on the next cycle.
  - Return to IDLE.
- Latency:
  - Request seen in IDLE to o_valid is 2 cycles (LATCH, ISSUE).
  - From the i_busy falling edge, o_done asserts 1 cycle later.
  - The minimum gap between consecutive o_valid pulses is 5 cycles plus the busy duration.
- Request changes:
  - i_req deasserting after the grant is ignored; the transaction completes and o_done still pulses.
  - A requester that keeps i_req high after o_done is eligible again in the next IDLE. Round-robin prevents starvation whenever PRIO0=0.
  - Requests that arrive simultaneously are resolved in the same IDLE cycle; non-winners wait without loss.
- o_valid is never asserted outside ISSUE.
- o_gnt has at most one bit set at any time.
- o_idle = (state==IDLE) && (i_req==0) && !i_busy.

Test Plan:
- Reset while in WAIT_LO with i_busy=1 → all outputs are at their reset values in the same cycle; after release with i_busy=0 and i_req=0, o_idle=1.
- i_req=3'b001, i_data[7:0]=8'h38, RS=0; busy model rises 3 cycles after valid and stays high 40 cycles → o_valid pulses once 2 cycles after the request; o_data=8'h38; o_done[0] pulses exactly once, 1 cycle after busy falls.
- PRIO0=1; i_req=3'b111 held continuously → grant order 0,0,0…; then drop req0 → order alternates 1,2,1,2; no o_valid overlaps busy.
- PRIO0=0; all three requesting with bytes 8'h41/8'h42/8'h43 → grant order 1,2,0,1,… starting from pointer=0; o_data matches the granted byte each time.
- Busy model never responds → o_timeout=1 exactly TMO=255 cycles after o_valid; o_done pulses; the next request is still served.
- i_busy held 1 externally while i_req=3'b010 → no o_valid until busy falls; then o_valid follows 2 cycles later.
